// File: rtl/digit_serial_sub_add.sv
// Digit-serial two's-complement subtractor/adder: DIGIT bits per clock, LSB digit first.
// Optional running-accumulate mode (operand A taken from d_s) enabled by SUBADD_ACCUM_EN.
module digit_serial_sub_add #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub_add,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_cin,
`ifdef SUBADD_ACCUM_EN
  input  logic             acc,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d_s,
  output logic             b_cout,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for start, results held
  // RUN   | one digit computed per cycle, busy=1
  // DONE  | one-cycle done pulse, new start accepted here too

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("digit_serial_sub_add: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  op_a, op_b;
  logic              op_sub;
  logic              chain;
  logic [CW-1:0]     count;
  logic              accept;
  logic              last_digit;
  logic [DIGIT-1:0]  x_dig, y_dig, dig_sum;
  logic              dig_cout;
  logic [WIDTH-1:0]  a_src;
  logic              new_msb;
  logic              ovf_nxt;

  assign accept     = start && (state != RUN);
  assign last_digit = (count == CW'(N - 1));

`ifdef SUBADD_ACCUM_EN
  assign a_src = acc ? d_s : a;
`else
  assign a_src = a;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_digit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One digit of ripple sub/add, seeded from the inter-digit chain register
  always_comb begin
    logic c;
    x_dig   = op_a[int'(count) * DIGIT +: DIGIT];
    y_dig   = op_b[int'(count) * DIGIT +: DIGIT];
    dig_sum = '0;
    c       = chain;
    for (int i = 0; i < DIGIT; i++) begin
      dig_sum[i] = x_dig[i] ^ y_dig[i] ^ c;
      if (op_sub) c = (~x_dig[i] & y_dig[i]) | (~x_dig[i] & c) | (y_dig[i] & c);
      else        c = (x_dig[i] & y_dig[i]) | (x_dig[i] & c) | (y_dig[i] & c);
    end
    dig_cout = c;
  end

  assign new_msb = dig_sum[DIGIT-1];
  assign ovf_nxt = op_sub ? ((op_a[WIDTH-1] != op_b[WIDTH-1]) && (new_msb != op_a[WIDTH-1]))
                          : ((op_a[WIDTH-1] == op_b[WIDTH-1]) && (new_msb != op_a[WIDTH-1]));

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      op_sub <= 1'b0;
      chain  <= 1'b0;
      count  <= '0;
      d_s    <= '0;
      b_cout <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      op_a   <= a_src;
      op_b   <= b;
      op_sub <= sub_add;
      chain  <= b_cin;
      count  <= '0;
      d_s    <= '0;
      b_cout <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == RUN) begin
      d_s[int'(count) * DIGIT +: DIGIT] <= dig_sum;
      chain <= dig_cout;
      if (last_digit) begin
        b_cout <= dig_cout;
        ovf    <= ovf_nxt;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_sub_add.sv
// Directed self-checking bench for digit_serial_sub_add (16/4 main instance, 8/1 and 8/8 narrow).
// Accumulate checks are built only when SUBADD_ACCUM_EN is defined.
module tb_digit_serial_sub_add;

  logic        clk = 1'b0;
  logic        rst, start, sub_add, b_cin, acc;
  logic [15:0] a, b, d_s;
  logic        busy, done, b_cout, ovf;

  logic        start8, sub8, cin8;
  logic [7:0]  a8, b8, ds_1, ds_8;
  logic        busy_1, done_1, bc_1, ovf_1;
  logic        busy_8, done_8, bc_8, ovf_8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_serial_sub_add #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sub_add(sub_add), .a(a), .b(b), .b_cin(b_cin),
`ifdef SUBADD_ACCUM_EN
    .acc(acc),
`endif
    .busy(busy), .done(done), .d_s(d_s), .b_cout(b_cout), .ovf(ovf));

  digit_serial_sub_add #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start8), .sub_add(sub8), .a(a8), .b(b8), .b_cin(cin8),
`ifdef SUBADD_ACCUM_EN
    .acc(1'b0),
`endif
    .busy(busy_1), .done(done_1), .d_s(ds_1), .b_cout(bc_1), .ovf(ovf_1));

  digit_serial_sub_add #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start8), .sub_add(sub8), .a(a8), .b(b8), .b_cin(cin8),
`ifdef SUBADD_ACCUM_EN
    .acc(1'b0),
`endif
    .busy(busy_8), .done(done_8), .d_s(ds_8), .b_cout(bc_8), .ovf(ovf_8));

  // Issue one op on the main instance; returns cycles from the start edge to done.
  task automatic run_op(input logic s, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic accv, output int lat);
    @(negedge clk);
    start = 1'b1; sub_add = s; a = av; b = bv; b_cin = cv; acc = accv;
    @(negedge clk);
    start = 1'b0; a = 16'(~av); b = 16'(~bv); b_cin = ~cv; sub_add = ~s; acc = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL op_timeout: done=%b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b need 0", done); end
    checks++; if (d_s !== 16'h0)   begin errors++; $display("FAIL reset_d_s: got %h need 0000", d_s); end
    checks++; if (b_cout !== 1'b0) begin errors++; $display("FAIL reset_b_cout: got %b need 0", b_cout); end
    checks++; if (ovf !== 1'b0)    begin errors++; $display("FAIL reset_ovf: got %b need 0", ovf); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    run_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, lat);
    checks++; if (lat != 5)          begin errors++; $display("FAIL add_latency: got %0d need 5", lat); end
    checks++; if (d_s !== 16'h2233)  begin errors++; $display("FAIL add_d_s: got %h need 2233", d_s); end
    checks++; if (b_cout !== 1'b0)   begin errors++; $display("FAIL add_b_cout: got %b need 0", b_cout); end
    checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL add_ovf: got %b need 0", ovf); end
  endtask

  task automatic test_boundaries();
    int lat;
    run_op(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0, lat);
    checks++; if (d_s !== 16'hFFFF) begin errors++; $display("FAIL sub_wrap_d_s: got %h need ffff", d_s); end
    checks++; if (b_cout !== 1'b1)  begin errors++; $display("FAIL sub_wrap_b_cout: got %b need 1", b_cout); end
    checks++; if (ovf !== 1'b0)     begin errors++; $display("FAIL sub_wrap_ovf: got %b need 0", ovf); end
    run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0, lat);
    checks++; if (d_s !== 16'h7FFF) begin errors++; $display("FAIL sub_ovf_d_s: got %h need 7fff", d_s); end
    checks++; if (b_cout !== 1'b0)  begin errors++; $display("FAIL sub_ovf_b_cout: got %b need 0", b_cout); end
    checks++; if (ovf !== 1'b1)     begin errors++; $display("FAIL sub_ovf_ovf: got %b need 1", ovf); end
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    checks++; if (d_s !== 16'h8000) begin errors++; $display("FAIL add_ovf_d_s: got %h need 8000", d_s); end
    checks++; if (b_cout !== 1'b0)  begin errors++; $display("FAIL add_ovf_b_cout: got %b need 0", b_cout); end
    checks++; if (ovf !== 1'b1)     begin errors++; $display("FAIL add_ovf_ovf: got %b need 1", ovf); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start = 1'b1; sub_add = 1'b0; a = 16'h1111; b = 16'h2222; b_cin = 1'b0; acc = 1'b0;
    @(negedge clk);
    start = 1'b0; lat = 1;
    @(negedge clk);
    lat = 2;
    start = 1'b1; sub_add = 1'b1; a = 16'h5555; b = 16'h5555; b_cin = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 3;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    checks++; if (lat != 5)         begin errors++; $display("FAIL busy_ignore_latency: got %0d need 5", lat); end
    checks++; if (d_s !== 16'h3333) begin errors++; $display("FAIL busy_ignore_d_s: got %h need 3333", d_s); end
    start = 1'b1; sub_add = 1'b1; a = 16'h0010; b = 16'h0001; b_cin = 1'b0;
    @(negedge clk);
    start = 1'b0; a = 16'hAAAA; b = 16'h0F0F; sub_add = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b need 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_low: got %b need 0", done); end
    lat = 1;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    checks++; if (lat != 5)         begin errors++; $display("FAIL b2b_latency: got %0d need 5", lat); end
    checks++; if (d_s !== 16'h000F) begin errors++; $display("FAIL b2b_d_s: got %h need 000f", d_s); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || d_s !== 16'h000F)
      begin errors++; $display("FAIL hold_after_done: done=%b d_s=%h need 0/000f", done, d_s); end
  endtask

  task automatic test_reset_midop();
    int lat;
    logic seen_done;
    @(negedge clk);
    start = 1'b1; sub_add = 1'b0; a = 16'h1234; b = 16'h1111; b_cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL abort_busy: got %b need 0", busy); end
    checks++; if (d_s !== 16'h0)  begin errors++; $display("FAIL abort_d_s: got %h need 0000", d_s); end
    seen_done = done;
    repeat (6) begin @(negedge clk); seen_done |= done; end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b need 0", seen_done); end
    run_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, lat);
    checks++; if (d_s !== 16'hFFFF) begin errors++; $display("FAIL sub_cin_d_s: got %h need ffff", d_s); end
    checks++; if (b_cout !== 1'b1)  begin errors++; $display("FAIL sub_cin_b_cout: got %b need 1", b_cout); end
  endtask

  task automatic test_narrow();
    int cyc, lat1, lat8;
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'd200; b8 = 8'd100; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    lat1 = 0; lat8 = 0;
    for (cyc = 1; cyc < 30 && lat1 == 0; cyc++) begin
      if (done_1 && lat1 == 0) lat1 = cyc;
      if (done_8 && lat8 == 0) lat8 = cyc;
      if (lat1 == 0) @(negedge clk);
    end
    checks++; if (lat1 != 9)       begin errors++; $display("FAIL d1_latency: got %0d need 9", lat1); end
    checks++; if (lat8 != 2)       begin errors++; $display("FAIL d8_latency: got %0d need 2", lat8); end
    checks++; if (ds_1 !== 8'h2D)  begin errors++; $display("FAIL d1_d_s: got %h need 2d", ds_1); end
    checks++; if (bc_1 !== 1'b1)   begin errors++; $display("FAIL d1_b_cout: got %b need 1", bc_1); end
    checks++; if (ds_8 !== 8'h2D)  begin errors++; $display("FAIL d8_d_s: got %h need 2d", ds_8); end
    checks++; if (bc_8 !== 1'b1)   begin errors++; $display("FAIL d8_b_cout: got %b need 1", bc_8); end
    checks++; if (ovf_1 !== 1'b0 || ovf_8 !== 1'b0)
      begin errors++; $display("FAIL narrow_ovf: got %b/%b need 0/0", ovf_1, ovf_8); end
  endtask

`ifdef SUBADD_ACCUM_EN
  task automatic test_accum();
    int lat;
    do_reset();
    run_op(1'b0, 16'hDEAD, 16'd5, 1'b0, 1'b1, lat);
    checks++; if (d_s !== 16'd5)   begin errors++; $display("FAIL acc_first: got %h need 0005", d_s); end
    run_op(1'b0, 16'hBEEF, 16'd7, 1'b0, 1'b1, lat);
    checks++; if (d_s !== 16'd12)  begin errors++; $display("FAIL acc_second: got %h need 000c", d_s); end
    run_op(1'b1, 16'h1234, 16'd20, 1'b0, 1'b1, lat);
    checks++; if (d_s !== 16'hFFF8) begin errors++; $display("FAIL acc_sub_d_s: got %h need fff8", d_s); end
    checks++; if (b_cout !== 1'b1)  begin errors++; $display("FAIL acc_sub_b_cout: got %b need 1", b_cout); end
  endtask
`endif

  // Random ops against a whole-word arithmetic reference.
  task automatic test_random();
    int lat;
    logic [15:0] prev, av, bv, aeff;
    logic [16:0] r;
    logic s, cv, accv, exp_ovf;
    do_reset();
    prev = 16'h0;
    for (int i = 0; i < 150; i++) begin
      av = 16'($urandom); bv = 16'($urandom);
      s = 1'($urandom); cv = 1'($urandom);
`ifdef SUBADD_ACCUM_EN
      accv = 1'($urandom);
`else
      accv = 1'b0;
`endif
      aeff = accv ? prev : av;
      r = s ? ({1'b0, aeff} - {1'b0, bv} - 17'(cv)) : ({1'b0, aeff} + {1'b0, bv} + 17'(cv));
      exp_ovf = s ? ((aeff[15] != bv[15]) && (r[15] != aeff[15]))
                  : ((aeff[15] == bv[15]) && (r[15] != aeff[15]));
      run_op(s, av, bv, cv, accv, lat);
      checks++;
      if (d_s !== r[15:0] || b_cout !== r[16] || ovf !== exp_ovf || lat != 5) begin
        errors++;
        $display("FAIL random_%0d: got d_s=%h bc=%b ovf=%b lat=%0d need %h/%b/%b/5",
                 i, d_s, b_cout, ovf, lat, r[15:0], r[16], exp_ovf);
      end
      prev = r[15:0];
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; sub_add = 1'b0; a = '0; b = '0; b_cin = 1'b0; acc = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    test_reset();
    test_add();
    test_boundaries();
    test_back_to_back();
    test_reset_midop();
    test_narrow();
`ifdef SUBADD_ACCUM_EN
    test_accum();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
